// File: rtl/exp_diff_serial.sv
// Bit-serial unsigned exponent subtractor for the FMAC alignment path.
// One full-adder cell is reused across WIDTH cycles to form a + ~b + 1.
// A missing final carry means a borrow occurred (a < b). In that case a
// second serial pass forms ~res + 1, so abs_diff is always |a - b|.
module exp_diff_serial #(
   parameter int WIDTH = 9
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             start_i,
   input  logic [WIDTH-1:0] a_i,
   input  logic [WIDTH-1:0] b_i,
   output logic             busy_o,
   output logic             done_o,
   output logic [WIDTH-1:0] abs_diff_o,
   output logic             a_lt_b_o
);

   localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      SUB  = 2'd1,
      NEG  = 2'd2,
      DONE = 2'd3
   } state_t;

   state_t           state_q;
   logic [WIDTH-1:0] opA_q;
   logic [WIDTH-1:0] opB_q;
   logic [WIDTH-1:0] res_q;
   logic [WIDTH-1:0] absDiff_q;
   logic [CNT_W-1:0] cnt_q;
   logic             carry_q;
   logic             aLtBNext_q;
   logic             aLtB_q;
   logic             busy_q;
   logic             done_q;

   logic             sum_d;
   logic             carry_d;
   logic [WIDTH-1:0] res_d;
   logic             lastBit;

   // The single full-adder cell. The new sum bit enters the result from the
   // MSB side, so after WIDTH steps the LSB-first bits line up in place.
   always_comb begin
      sum_d   = opA_q[0] ^ opB_q[0] ^ carry_q;
      carry_d = (opA_q[0] & opB_q[0]) | (opA_q[0] & carry_q) | (opB_q[0] & carry_q);
      res_d   = {sum_d, res_q[WIDTH-1:1]};
      lastBit = (cnt_q == CNT_W'(WIDTH - 1));
   end

   // Control FSM plus serial datapath. Outputs are registered, so busy and
   // done switch on the same edge as the state that they describe.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q    <= IDLE;
         opA_q      <= '0;
         opB_q      <= '0;
         res_q      <= '0;
         absDiff_q  <= '0;
         cnt_q      <= '0;
         carry_q    <= 1'b0;
         aLtBNext_q <= 1'b0;
         aLtB_q     <= 1'b0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               done_q <= 1'b0;
               if (start_i) begin
                  opA_q   <= a_i;
                  opB_q   <= ~b_i;
                  carry_q <= 1'b1;
                  cnt_q   <= '0;
                  res_q   <= '0;
                  busy_q  <= 1'b1;
                  state_q <= SUB;
               end
            end
            SUB: begin
               opA_q   <= opA_q >> 1;
               opB_q   <= opB_q >> 1;
               res_q   <= res_d;
               carry_q <= carry_d;
               cnt_q   <= cnt_q + CNT_W'(1);
               if (lastBit) begin
                  if (carry_d) begin
                     aLtBNext_q <= 1'b0;
                     aLtB_q     <= 1'b0;
                     absDiff_q  <= res_d;
                     busy_q     <= 1'b0;
                     done_q     <= 1'b1;
                     state_q    <= DONE;
                  end else begin
                     opA_q      <= ~res_d;
                     opB_q      <= '0;
                     carry_q    <= 1'b1;
                     cnt_q      <= '0;
                     aLtBNext_q <= 1'b1;
                     state_q    <= NEG;
                  end
               end
            end
            NEG: begin
               opA_q   <= opA_q >> 1;
               opB_q   <= opB_q >> 1;
               res_q   <= res_d;
               carry_q <= carry_d;
               cnt_q   <= cnt_q + CNT_W'(1);
               if (lastBit) begin
                  aLtB_q    <= aLtBNext_q;
                  absDiff_q <= res_d;
                  busy_q    <= 1'b0;
                  done_q    <= 1'b1;
                  state_q   <= DONE;
               end
            end
            DONE: begin
               done_q  <= 1'b0;
               state_q <= IDLE;
            end
            default: begin
               busy_q  <= 1'b0;
               done_q  <= 1'b0;
               state_q <= IDLE;
            end
         endcase
      end
   end

   assign busy_o     = busy_q;
   assign done_o     = done_q;
   assign abs_diff_o = absDiff_q;
   assign a_lt_b_o   = aLtB_q;

endmodule

// File: tb/tb_exp_diff_serial.sv
// Directed and randomized bench for the serial exponent subtractor.
module tb_exp_diff_serial;

   localparam int WIDTH = 9;
   localparam int TIMEOUT = 60;

   logic             clk;
   logic             rst;
   logic             start;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] absDiff;
   logic             aLtB;

   int compared   = 0;
   int mismatched = 0;
   int doneTotal  = 0;
   int overlap    = 0;

   exp_diff_serial #(.WIDTH(WIDTH)) dut (
      .clk_i      (clk),
      .rst_i      (rst),
      .start_i    (start),
      .a_i        (a),
      .b_i        (b),
      .busy_o     (busy),
      .done_o     (done),
      .abs_diff_o (absDiff),
      .a_lt_b_o   (aLtB)
   );

   // Free-running clock with a 10-unit period.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Count done pulses and catch busy/done overlap, sampling mid-cycle.
   always @(negedge clk) begin
      if (done) doneTotal++;
      if (busy && done) overlap++;
   end

   // Every comparison in the bench goes through this task.
   task automatic checkOutput(input string tag, input int observed, input int expected);
      compared++;
      if (observed !== expected) begin
         mismatched++;
         $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
      end
   endtask

   task automatic stepCycle();
      @(posedge clk);
      #1;
   endtask

   // Issue one start and wait for done. doneEdge is the number of edges
   // after the accept edge at which done is first seen. The task returns
   // once the DUT is back in IDLE.
   task automatic applyStimulus(input logic [WIDTH-1:0] av, input logic [WIDTH-1:0] bv,
                                output int doneEdge, output int busyCnt);
      bit seen;
      seen     = 0;
      doneEdge = 0;
      busyCnt  = 0;
      a        = av;
      b        = bv;
      start    = 1'b1;
      stepCycle();
      start = 1'b0;
      a     = ~av;
      b     = ~bv;
      if (busy) busyCnt++;
      for (int i = 1; i <= TIMEOUT; i++) begin
         stepCycle();
         if (busy) busyCnt++;
         if (done) begin
            doneEdge = i;
            seen     = 1;
            break;
         end
      end
      if (!seen) checkOutput("doneTimeout", 0, 1);
      stepCycle();
   endtask

   task automatic directed(input string tag, input int av, input int bv,
                           input int expDiff, input int expLt);
      int doneEdge;
      int busyCnt;
      int expEdge;
      applyStimulus(WIDTH'(av), WIDTH'(bv), doneEdge, busyCnt);
      expEdge = expLt ? 2 * WIDTH : WIDTH;
      checkOutput({tag, "_doneEdge"}, doneEdge, expEdge);
      checkOutput({tag, "_busyCycles"}, busyCnt, expEdge);
      checkOutput({tag, "_absDiff"}, int'(absDiff), expDiff);
      checkOutput({tag, "_aLtB"}, int'(aLtB), expLt);
   endtask

   initial begin
      int doneEdge;
      int busyCnt;
      int donesBefore;
      int accepted;
      logic [WIDTH-1:0] ra;
      logic [WIDTH-1:0] rb;
      int expDiff;
      int expLt;
      bit seen;

      rst   = 1'b1;
      start = 1'b0;
      a     = '0;
      b     = '0;
      stepCycle();
      stepCycle();
      rst = 1'b0;
      checkOutput("reset_busy", int'(busy), 0);
      checkOutput("reset_done", int'(done), 0);
      checkOutput("reset_absDiff", int'(absDiff), 0);
      checkOutput("reset_aLtB", int'(aLtB), 0);
      stepCycle();

      directed("ge200_100", 200, 100, 100, 0);
      directed("lt100_200", 100, 200, 100, 1);
      for (int i = 0; i < 3; i++) stepCycle();
      checkOutput("hold_absDiff", int'(absDiff), 100);
      checkOutput("hold_aLtB", int'(aLtB), 1);
      checkOutput("hold_done", int'(done), 0);

      directed("ext0_511", 0, 511, 511, 1);
      directed("ext511_0", 511, 0, 511, 0);
      directed("eq255", 255, 255, 0, 0);

      // Start held high with operands changing every cycle while busy.
      donesBefore = doneTotal;
      a     = WIDTH'(50);
      b     = WIDTH'(60);
      start = 1'b1;
      stepCycle();
      seen = 0;
      for (int i = 1; i <= TIMEOUT; i++) begin
         a = WIDTH'($urandom);
         b = WIDTH'($urandom);
         stepCycle();
         if (done) begin
            seen = 1;
            break;
         end
      end
      if (!seen) checkOutput("held_doneTimeout", 0, 1);
      checkOutput("held_absDiff", int'(absDiff), 10);
      checkOutput("held_aLtB", int'(aLtB), 1);
      a = WIDTH'(5);
      b = WIDTH'(3);
      stepCycle();
      checkOutput("held_idleBusy", int'(busy), 0);
      checkOutput("held_idleDone", int'(done), 0);
      checkOutput("held_doneCount", doneTotal - donesBefore, 1);
      stepCycle();
      checkOutput("held_reaccept", int'(busy), 1);
      start = 1'b0;
      seen  = 0;
      for (int i = 1; i <= TIMEOUT; i++) begin
         stepCycle();
         if (done) begin
            seen = 1;
            break;
         end
      end
      if (!seen) checkOutput("held2_doneTimeout", 0, 1);
      checkOutput("held2_absDiff", int'(absDiff), 2);
      checkOutput("held2_aLtB", int'(aLtB), 0);
      stepCycle();

      // Reset in the middle of an operation aborts it silently.
      donesBefore = doneTotal;
      a     = WIDTH'(300);
      b     = WIDTH'(7);
      start = 1'b1;
      stepCycle();
      start = 1'b0;
      for (int i = 0; i < 3; i++) stepCycle();
      rst = 1'b1;
      stepCycle();
      rst = 1'b0;
      checkOutput("abort_busy", int'(busy), 0);
      checkOutput("abort_absDiff", int'(absDiff), 0);
      checkOutput("abort_aLtB", int'(aLtB), 0);
      for (int i = 0; i < 25; i++) stepCycle();
      checkOutput("abort_noDone", doneTotal - donesBefore, 0);
      directed("after300_7", 300, 7, 293, 0);

      // Randomized back-to-back operations against a reference model.
      donesBefore = doneTotal;
      accepted    = 0;
      for (int n = 0; n < 1000; n++) begin
         ra = WIDTH'($urandom);
         rb = WIDTH'($urandom);
         if (n % 50 == 0) rb = ra;
         expLt   = (ra < rb) ? 1 : 0;
         expDiff = expLt ? (int'(rb) - int'(ra)) : (int'(ra) - int'(rb));
         applyStimulus(ra, rb, doneEdge, busyCnt);
         accepted++;
         checkOutput("rand_absDiff", int'(absDiff), expDiff);
         checkOutput("rand_aLtB", int'(aLtB), expLt);
         checkOutput("rand_doneEdge", doneEdge, expLt ? 2 * WIDTH : WIDTH);
      end
      checkOutput("rand_doneCount", doneTotal - donesBefore, accepted);
      checkOutput("busyDoneOverlap", overlap, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule

// File: doc/exp_diff_serial.md
Name: exp_diff_serial

Overview:
- Bit-serial unsigned subtractor for the FMAC exponent path.
- Computes |a - b| and a_lt_b using one full-adder cell iterated over WIDTH cycles, with a second serial pass to negate when a < b.
- Feeds the alignment shifter: abs_diff is the shift amount, and a_lt_b selects which mantissa gets shifted.
- Complements the combinational ripple adders: it trades area for latency and uses a start/done handshake.

Parameters:
- WIDTH, 9, operand and result width in bits (biased exponent width incl. overflow bit).

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request; sampled only in IDLE.
- a  input  WIDTH  minuend, captured on accepted start.
- b  input  WIDTH  subtrahend, captured on accepted start.
- busy  output  1  high in SUB and NEG states.
- done  output  1  one-cycle pulse; abs_diff and a_lt_b are valid in this cycle.
- abs_diff  output  WIDTH  |a - b|, registered; holds until the next done.
- a_lt_b  output  1  1 when a < b (unsigned), registered; holds until the next done.

Behaviour:
- Reset (rst high at a clock edge):
  - state=IDLE; busy=0, done=0, abs_diff=0, a_lt_b=0.
  - Shift registers, carry and counter cleared.
  - Reset mid-operation aborts without producing a done; it overrides start in the same cycle.
- States: IDLE, SUB, NEG, DONE.
- IDLE:
  - On start=1, capture opA<=a, opB<=~b, carry<=1, cnt<=0, go SUB.
  - start=0 keeps IDLE.
- SUB (WIDTH cycles):
  - Each cycle: s = opA[0]^opB[0]^carry; carry <= majority(opA[0],opB[0],carry).
  - Shift opA and opB right by 1; shift s into res from the MSB side; cnt++.
  - After the cycle with cnt==WIDTH-1, final carry-out==1 means a>=b: go DONE with a_lt_b_next=0.
  - Final carry-out==0 (borrow) means a<b: load opA<=~res (full-width value incl. the bit shifted in this cycle), opB<=0, carry<=1, cnt<=0, a_lt_b_next=1, go NEG.
- NEG (WIDTH cycles):
  - Same serial datapath, computing ~res + 1 (two's-complement negate); go DONE after cnt==WIDTH-1.
  - The carry-out of this pass is discarded.
- DONE (1 cycle):
  - done=1; abs_diff<=res and a_lt_b<=a_lt_b_next are written at the edge entering DONE, so they are valid while done=1.
  - Next state IDLE.
  - start during DONE is ignored.
- Latency, counting start sampled at edge E0:
  - a>=b: done is high in the cycle after edge E0+WIDTH; WIDTH+1 cycles total, 10 for WIDTH=9.
  - a<b: done is high in the cycle after edge E0+2*WIDTH; 2*WIDTH+1 cycles total, 19 for WIDTH=9.
  - Minimum start-to-start spacing is latency+1 (IDLE is re-entered before the next accept).
- start held high or pulsed while busy or in DONE is ignored; no queueing.
- a, b may change after the accept edge without affecting the result.
- busy=1 exactly in SUB/NEG; busy and done are never high together.
- Arithmetic is unsigned, modulo 2^WIDTH.
- a==b: no borrow, abs_diff=0, a_lt_b=0, short latency.
- Extremes: a=0,b=2^WIDTH-1 gives abs_diff=2^WIDTH-1, a_lt_b=1. a=2^WIDTH-1,b=0 gives abs_diff=2^WIDTH-1, a_lt_b=0.
- No result is ever a negated-zero artefact: NEG is entered only on a borrow, so res is nonzero there.

Test Plan:
- Reset, then a=200,b=100, start for 1 cycle -> busy high 9 cycles, done pulse 10 cycles after start edge; abs_diff=100, a_lt_b=0.
- a=100,b=200 -> busy high 18 cycles, done 19 cycles after start edge; abs_diff=100, a_lt_b=1; outputs hold after done.
- Extremes: a=0,b=511 -> abs_diff=511, a_lt_b=1. a=511,b=0 -> abs_diff=511, a_lt_b=0. a=b=255 -> abs_diff=0, a_lt_b=0, 10-cycle latency.
- Accept a=50,b=60, hold start high and change a/b every cycle while busy -> exactly one done, abs_diff=10, a_lt_b=1. The next accept happens only on the cycle after returning to IDLE.
- Accept a=300,b=7, assert rst at cycle 4 -> busy=0, done never pulses, abs_diff=0, a_lt_b=0. A fresh start then yields abs_diff=293, a_lt_b=0.
- Randomized a,b (1000 pairs, back-to-back starts) vs. reference model -> all results match; the done count equals the accepted start count.
